// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the CPU, loader and memory-side signals of the shared
// memory port. The slave modport is the arbiter. The master modport is its environment:
// the two requesters plus the memory macro.
interface mem_port_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   // CPU requester
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_adr;
   logic [DATA_W-1:0] cpu_wd;
   logic [DATA_W-1:0] cpu_rd;
   logic              cpu_ack;
   logic              cpu_stall;
   // Loader / debug requester
   logic              ld_req;
   logic              ld_we;
   logic [ADDR_W-1:0] ld_adr;
   logic [DATA_W-1:0] ld_wd;
   logic [DATA_W-1:0] ld_rd;
   logic              ld_ack;
   // Memory macro side
   logic              mem_we;
   logic [ADDR_W-1:0] mem_adr;
   logic [DATA_W-1:0] mem_wd;
   logic [DATA_W-1:0] mem_rd;

   modport slave (
      input  cpu_req, cpu_we, cpu_adr, cpu_wd,
      output cpu_rd, cpu_ack, cpu_stall,
      input  ld_req, ld_we, ld_adr, ld_wd,
      output ld_rd, ld_ack,
      output mem_we, mem_adr, mem_wd,
      input  mem_rd
   );

   modport master (
      output cpu_req, cpu_we, cpu_adr, cpu_wd,
      input  cpu_rd, cpu_ack, cpu_stall,
      output ld_req, ld_we, ld_adr, ld_wd,
      input  ld_rd, ld_ack,
      input  mem_we, mem_adr, mem_wd,
      output mem_rd
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises CPU and loader accesses onto the single unified memory,
// inserting WAIT_CYCLES wait states and returning a one-cycle ack per access.
// Optional loader starvation guard is enabled by defining MEM_ARB_STARVE_GUARD_EN;
// without it the CPU always has strict priority.
module mem_port_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 32,
   parameter int WAIT_CYCLES  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_LD  = 1'b1
   } owner_t;

   state_t            r_state;
   state_t            w_state_next;
   owner_t            r_owner;
   logic              r_we;
   logic [ADDR_W-1:0] r_adr;
   logic [DATA_W-1:0] r_wd;
   logic [3:0]        r_cnt;
   logic [DATA_W-1:0] r_cpu_rd;
   logic [DATA_W-1:0] r_ld_rd;
   logic              r_cpu_ack;
   logic              r_ld_ack;
   logic              r_mem_we;

   logic              w_any_req;
   logic              w_ld_wins;
   logic              w_grant;
   logic              w_done;

   assign w_any_req = bus.cpu_req | bus.ld_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [3:0] r_starve;
   logic       w_starved;

   assign w_starved = (r_starve == 4'(STARVE_LIMIT));
   // The loader only beats a requesting CPU once it has been passed over STARVE_LIMIT times
   assign w_ld_wins = bus.ld_req & (~bus.cpu_req | w_starved);

   // Count CPU grants made over a waiting loader; clear when the loader wins or stops asking
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_starve <= '0;
      end else if (w_grant) begin
         if (w_ld_wins || !bus.ld_req) begin
            r_starve <= '0;
         end else if (!w_starved) begin
            r_starve <= r_starve + 4'd1;
         end
      end
   end
`else
   logic w_unused_starve_limit;

   // The limit only matters to the guard; strict CPU priority otherwise
   assign w_unused_starve_limit = (STARVE_LIMIT != 0);
   assign w_ld_wins = bus.ld_req & ~bus.cpu_req;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: grant in IDLE, count out the wait states in BUSY, one RESP cycle, back to IDLE
   always_comb begin
      w_state_next = r_state;
      w_grant      = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_grant      = 1'b1;
               w_state_next = S_BUSY;
            end
         end
         S_BUSY: begin
            if (r_cnt == 4'd0) begin
               w_done       = 1'b1;
               w_state_next = S_RESP;
            end
         end
         S_RESP: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Latch the winner's access at grant; these drive the memory and hold while idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_owner <= OWN_CPU;
         r_we    <= 1'b0;
         r_adr   <= '0;
         r_wd    <= '0;
      end else if (w_grant) begin
         r_owner <= w_ld_wins ? OWN_LD : OWN_CPU;
         r_we    <= w_ld_wins ? bus.ld_we  : bus.cpu_we;
         r_adr   <= w_ld_wins ? bus.ld_adr : bus.cpu_adr;
         r_wd    <= w_ld_wins ? bus.ld_wd  : bus.cpu_wd;
      end
   end

   // Wait-state counter: loaded at grant, decremented through BUSY down to zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (w_grant) begin
         r_cnt <= 4'(WAIT_CYCLES);
      end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Write strobe lives only in the first BUSY cycle so each access writes exactly once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mem_we <= 1'b0;
      end else begin
         r_mem_we <= w_grant & (w_ld_wins ? bus.ld_we : bus.cpu_we);
      end
   end

   // Completion: pulse the owner's ack for the RESP cycle and capture read data for reads
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cpu_ack <= 1'b0;
         r_ld_ack  <= 1'b0;
         r_cpu_rd  <= '0;
         r_ld_rd   <= '0;
      end else begin
         r_cpu_ack <= w_done & (r_owner == OWN_CPU);
         r_ld_ack  <= w_done & (r_owner == OWN_LD);
         if (w_done && !r_we) begin
            if (r_owner == OWN_CPU) begin
               r_cpu_rd <= bus.mem_rd;
            end else begin
               r_ld_rd <= bus.mem_rd;
            end
         end
      end
   end

   assign bus.mem_we    = r_mem_we;
   assign bus.mem_adr   = r_adr;
   assign bus.mem_wd    = r_wd;
   assign bus.cpu_rd    = r_cpu_rd;
   assign bus.cpu_ack   = r_cpu_ack;
   assign bus.ld_rd     = r_ld_rd;
   assign bus.ld_ack    = r_ld_ack;
   // The CPU FSM holds while its request is outstanding, released in the ack cycle
   assign bus.cpu_stall = bus.cpu_req & ~r_cpu_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench. u_dut0 runs WAIT_CYCLES=1 with
// STARVE_LIMIT=2; u_dut1 runs WAIT_CYCLES=0 for back-to-back timing.
// Starvation-order expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;
   localparam int DW = 32;
   localparam int AW = 32;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
   mem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

   mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(1), .STARVE_LIMIT(2)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (if0)
   );

   mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(0), .STARVE_LIMIT(4)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (if1)
   );

   // Memory model for u_dut0: remembers the last write, fixed pattern elsewhere
   logic        wr_valid = 1'b0;
   logic [31:0] wr_adr   = '0;
   logic [31:0] wr_data  = '0;

   always @(posedge clk) begin
      if (if0.mem_we === 1'b1) begin
         wr_valid <= 1'b1;
         wr_adr   <= if0.mem_adr;
         wr_data  <= if0.mem_wd;
      end
   end

   always_comb begin
      if (wr_valid && if0.mem_adr == wr_adr) if0.mem_rd = wr_data;
      else if (if0.mem_adr == 32'h10)        if0.mem_rd = 32'hE3A01005;
      else                                   if0.mem_rd = {16'hC0DE, if0.mem_adr[15:0]};
   end

   // Memory model for u_dut1: data is a function of the address
   assign if1.mem_rd = 32'hA500_0000 | if1.mem_adr;

   // One access on u_dut0, reporting latency, write pulses and stall behaviour
   task automatic run0(input bit is_cpu, input bit we, input logic [31:0] adr,
                       input logic [31:0] wd, output int lat, output int we_cnt,
                       output logic [31:0] seen_adr, output logic [31:0] seen_wd,
                       output bit other_ack, output int stall_err);
      lat = -1; we_cnt = 0; seen_adr = '0; seen_wd = '0; other_ack = 1'b0; stall_err = 0;
      @(posedge clk); #1;
      if (is_cpu) begin
         if0.cpu_we = we; if0.cpu_adr = adr; if0.cpu_wd = wd; if0.cpu_req = 1'b1;
      end else begin
         if0.ld_we = we; if0.ld_adr = adr; if0.ld_wd = wd; if0.ld_req = 1'b1;
      end
      #1;
      if (is_cpu && if0.cpu_stall !== 1'b1) stall_err++;
      for (int k = 1; k <= 20 && lat < 0; k++) begin
         @(posedge clk); #1;
         if (if0.mem_we === 1'b1) begin
            we_cnt++; seen_adr = if0.mem_adr; seen_wd = if0.mem_wd;
         end
         if (is_cpu) begin
            if (if0.ld_ack !== 1'b0) other_ack = 1'b1;
            if (if0.cpu_stall !== ~if0.cpu_ack) stall_err++;
            if (if0.cpu_ack === 1'b1) begin lat = k; if0.cpu_req = 1'b0; end
         end else begin
            if (if0.cpu_ack !== 1'b0) other_ack = 1'b1;
            if (if0.ld_ack === 1'b1) begin lat = k; if0.ld_req = 1'b0; end
         end
      end
      if0.cpu_req = 1'b0;
      if0.ld_req  = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_total++; if (if0.cpu_ack !== 1'b0) $display("FAIL rst_cpu_ack: got %b want 0", if0.cpu_ack); else n_pass++;
      n_total++; if (if0.ld_ack !== 1'b0) $display("FAIL rst_ld_ack: got %b want 0", if0.ld_ack); else n_pass++;
      n_total++; if (if0.mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", if0.mem_we); else n_pass++;
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      n_total++; if (if0.cpu_rd !== 32'h0) $display("FAIL rst_cpu_rd: got %h want 0", if0.cpu_rd); else n_pass++;
      n_total++; if (if0.ld_rd !== 32'h0) $display("FAIL rst_ld_rd: got %h want 0", if0.ld_rd); else n_pass++;
      n_total++; if (if0.mem_adr !== 32'h0) $display("FAIL rst_mem_adr: got %h want 0", if0.mem_adr); else n_pass++;
      n_total++; if (if0.mem_wd !== 32'h0) $display("FAIL rst_mem_wd: got %h want 0", if0.mem_wd); else n_pass++;
      n_total++; if (if0.cpu_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", if0.cpu_stall); else n_pass++;
      n_total++; if (if1.cpu_ack !== 1'b0) $display("FAIL rst_dut1_ack: got %b want 0", if1.cpu_ack); else n_pass++;
      $display("reset: released, outputs idle");
   endtask

   task automatic test_cpu_read();
      int lat, we_cnt, stall_err; logic [31:0] sa, sw; bit oth;
      run0(1'b1, 1'b0, 32'h10, 32'h0, lat, we_cnt, sa, sw, oth, stall_err);
      $display("cpu read 0x10: ack cycle %0d rd=%h", lat, if0.cpu_rd);
      n_total++; if (lat !== 3) $display("FAIL cpu_rd_lat: got %0d want 3", lat); else n_pass++;
      n_total++; if (if0.cpu_rd !== 32'hE3A01005) $display("FAIL cpu_rd_data: got %h want e3a01005", if0.cpu_rd); else n_pass++;
      n_total++; if (oth !== 1'b0) $display("FAIL cpu_rd_ld_ack: got %b want 0", oth); else n_pass++;
      n_total++; if (we_cnt !== 0) $display("FAIL cpu_rd_we: got %0d pulses want 0", we_cnt); else n_pass++;
      n_total++; if (stall_err !== 0) $display("FAIL cpu_rd_stall: got %0d bad cycles want 0", stall_err); else n_pass++;
   endtask

   task automatic test_ld_write();
      int lat, we_cnt, stall_err; logic [31:0] sa, sw; bit oth;
      run0(1'b0, 1'b0, 32'h10, 32'h0, lat, we_cnt, sa, sw, oth, stall_err);
      $display("ld read 0x10: ack cycle %0d rd=%h", lat, if0.ld_rd);
      n_total++; if (if0.ld_rd !== 32'hE3A01005) $display("FAIL ld_rd_data: got %h want e3a01005", if0.ld_rd); else n_pass++;
      run0(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, lat, we_cnt, sa, sw, oth, stall_err);
      $display("ld write 0x20: ack cycle %0d we pulses %0d adr=%h wd=%h", lat, we_cnt, sa, sw);
      n_total++; if (lat !== 3) $display("FAIL ld_wr_lat: got %0d want 3", lat); else n_pass++;
      n_total++; if (we_cnt !== 1) $display("FAIL ld_wr_pulses: got %0d want 1", we_cnt); else n_pass++;
      n_total++; if (sa !== 32'h20) $display("FAIL ld_wr_adr: got %h want 20", sa); else n_pass++;
      n_total++; if (sw !== 32'hDEADBEEF) $display("FAIL ld_wr_wd: got %h want deadbeef", sw); else n_pass++;
      n_total++; if (if0.ld_rd !== 32'hE3A01005) $display("FAIL ld_wr_rd_kept: got %h want e3a01005", if0.ld_rd); else n_pass++;
      n_total++; if (oth !== 1'b0) $display("FAIL ld_wr_cpu_ack: got %b want 0", oth); else n_pass++;
      run0(1'b1, 1'b0, 32'h20, 32'h0, lat, we_cnt, sa, sw, oth, stall_err);
      $display("cpu readback 0x20: ack cycle %0d rd=%h", lat, if0.cpu_rd);
      n_total++; if (if0.cpu_rd !== 32'hDEADBEEF) $display("FAIL readback: got %h want deadbeef", if0.cpu_rd); else n_pass++;
   endtask

   task automatic test_simultaneous();
      int cpu_lat = -1, ld_lat = -1;
      logic stall2 = 1'bx, stall3 = 1'bx;
      @(posedge clk); #1;
      if0.cpu_we = 1'b0; if0.cpu_adr = 32'h10; if0.cpu_req = 1'b1;
      if0.ld_we  = 1'b0; if0.ld_adr  = 32'h20; if0.ld_req  = 1'b1;
      for (int k = 1; k <= 20 && ld_lat < 0; k++) begin
         @(posedge clk); #1;
         if (k == 2) stall2 = if0.cpu_stall;
         if (k == 3) stall3 = if0.cpu_stall;
         if (if0.cpu_ack === 1'b1 && cpu_lat < 0) begin cpu_lat = k; if0.cpu_req = 1'b0; end
         if (if0.ld_ack === 1'b1 && ld_lat < 0) begin ld_lat = k; if0.ld_req = 1'b0; end
      end
      if0.cpu_req = 1'b0; if0.ld_req = 1'b0;
      $display("simultaneous: cpu ack %0d ld ack %0d", cpu_lat, ld_lat);
      n_total++; if (cpu_lat !== 3) $display("FAIL sim_cpu_lat: got %0d want 3", cpu_lat); else n_pass++;
      n_total++; if (ld_lat !== 7) $display("FAIL sim_ld_lat: got %0d want 7", ld_lat); else n_pass++;
      n_total++; if (stall2 !== 1'b1) $display("FAIL sim_stall_c2: got %b want 1", stall2); else n_pass++;
      n_total++; if (stall3 !== 1'b0) $display("FAIL sim_stall_c3: got %b want 0", stall3); else n_pass++;
      n_total++; if (if0.ld_rd !== 32'hDEADBEEF) $display("FAIL sim_ld_rd: got %h want deadbeef", if0.ld_rd); else n_pass++;
   endtask

   task automatic test_starve();
      logic [5:0] got = '1;
      logic [5:0] exp_order;
      int n = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_order = 6'b100100;
`else
      exp_order = 6'b000000;
`endif
      @(posedge clk); #1;
      if0.cpu_we = 1'b0; if0.cpu_adr = 32'h40; if0.cpu_req = 1'b1;
      if0.ld_we  = 1'b0; if0.ld_adr  = 32'h44; if0.ld_req  = 1'b1;
      for (int k = 1; k <= 60 && n < 6; k++) begin
         @(posedge clk); #1;
         if (if0.cpu_ack === 1'b1) begin got[n] = 1'b0; n++; end
         else if (if0.ld_ack === 1'b1) begin got[n] = 1'b1; n++; end
      end
      if0.cpu_req = 1'b0; if0.ld_req = 1'b0;
      $display("starvation: %0d grants, order (bit i=1 means loader) %b", n, got);
      n_total++; if (n !== 6) $display("FAIL starve_count: got %0d want 6", n); else n_pass++;
      for (int i = 0; i < 6; i++) begin
         n_total++;
         if (got[i] !== exp_order[i]) $display("FAIL starve_grant%0d: got %b want %b", i, got[i], exp_order[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_midaccess();
      int lat = -1;
      @(posedge clk); #1;
      if0.cpu_we = 1'b0; if0.cpu_adr = 32'h10; if0.cpu_req = 1'b1;
      @(posedge clk); #1;
      #2; reset = 1'b0; #1;
      n_total++; if (if0.cpu_ack !== 1'b0) $display("FAIL mrst_cpu_ack: got %b want 0", if0.cpu_ack); else n_pass++;
      n_total++; if (if0.ld_ack !== 1'b0) $display("FAIL mrst_ld_ack: got %b want 0", if0.ld_ack); else n_pass++;
      n_total++; if (if0.mem_we !== 1'b0) $display("FAIL mrst_mem_we: got %b want 0", if0.mem_we); else n_pass++;
      n_total++; if (if0.cpu_rd !== 32'h0) $display("FAIL mrst_cpu_rd: got %h want 0", if0.cpu_rd); else n_pass++;
      n_total++; if (if0.mem_adr !== 32'h0) $display("FAIL mrst_mem_adr: got %h want 0", if0.mem_adr); else n_pass++;
      #2; reset = 1'b1;
      for (int k = 1; k <= 20 && lat < 0; k++) begin
         @(posedge clk); #1;
         if (if0.cpu_ack === 1'b1) begin lat = k; if0.cpu_req = 1'b0; end
      end
      if0.cpu_req = 1'b0;
      $display("reset mid-access: restart ack cycle %0d rd=%h", lat, if0.cpu_rd);
      n_total++; if (lat !== 3) $display("FAIL mrst_restart_lat: got %0d want 3", lat); else n_pass++;
      n_total++; if (if0.cpu_rd !== 32'hE3A01005) $display("FAIL mrst_restart_rd: got %h want e3a01005", if0.cpu_rd); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int ack_k[2] = '{-1, -1};
      logic [31:0] rd[2] = '{32'h0, 32'h0};
      int n = 0;
      @(posedge clk); #1;
      if1.cpu_we = 1'b0; if1.cpu_adr = 32'h0; if1.cpu_req = 1'b1;
      for (int k = 1; k <= 30 && n < 2; k++) begin
         @(posedge clk); #1;
         if (if1.cpu_ack === 1'b1) begin
            ack_k[n] = k; rd[n] = if1.cpu_rd; n++;
            if1.cpu_adr = 32'h4;
         end
      end
      if1.cpu_req = 1'b0;
      $display("back-to-back W=0: acks at %0d and %0d, rd %h then %h", ack_k[0], ack_k[1], rd[0], rd[1]);
      n_total++; if (ack_k[0] !== 2) $display("FAIL b2b_first_lat: got %0d want 2", ack_k[0]); else n_pass++;
      n_total++; if (ack_k[1] - ack_k[0] !== 3) $display("FAIL b2b_spacing: got %0d want 3", ack_k[1] - ack_k[0]); else n_pass++;
      n_total++; if (rd[0] !== 32'hA500_0000) $display("FAIL b2b_rd0: got %h want a5000000", rd[0]); else n_pass++;
      n_total++; if (rd[1] !== 32'hA500_0004) $display("FAIL b2b_rd1: got %h want a5000004", rd[1]); else n_pass++;
   endtask

   initial begin
      if0.cpu_req = 1'b0; if0.cpu_we = 1'b0; if0.cpu_adr = '0; if0.cpu_wd = '0;
      if0.ld_req  = 1'b0; if0.ld_we  = 1'b0; if0.ld_adr  = '0; if0.ld_wd  = '0;
      if1.cpu_req = 1'b0; if1.cpu_we = 1'b0; if1.cpu_adr = '0; if1.cpu_wd = '0;
      if1.ld_req  = 1'b0; if1.ld_we  = 1'b0; if1.ld_adr  = '0; if1.ld_wd  = '0;
      test_reset();
      test_cpu_read();
      test_ld_write();
      test_simultaneous();
      test_starve();
      test_reset_midaccess();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle core between two requesters: the CPU (fetch and load/store) and a program loader/debug port.
- Sits between the core's memory interface (address selected by AdrSrc, write enable derived from MemW) and the memory macro.
- Serialises accesses, inserts fixed wait states and returns read data with a one-cycle ack.
- Drives a stall to the CPU so the main FSM holds its state while an access is pending.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 32, address width.
- WAIT_CYCLES, 1, extra memory latency cycles (0..15).
- STARVE_LIMIT, 4, consecutive CPU grants allowed while the loader waits (guard feature only; 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- cpu_req  in  1  CPU access request; held with we/adr/wd stable until cpu_ack.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_adr  in  ADDR_W  CPU address.
- cpu_wd  in  DATA_W  CPU write data.
- cpu_rd  out  DATA_W  CPU read data; valid while cpu_ack=1 and held afterwards.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational).
- ld_req  in  1  loader request; same rules as cpu_req.
- ld_we  in  1  loader write.
- ld_adr  in  ADDR_W  loader address.
- ld_wd  in  DATA_W  loader write data.
- ld_rd  out  DATA_W  loader read data.
- ld_ack  out  1  loader completion pulse.
- mem_we  out  1  memory write strobe.
- mem_adr  out  ADDR_W  memory address.
- mem_wd  out  DATA_W  memory write data.
- mem_rd  in  DATA_W  memory read data, valid WAIT_CYCLES+1 cycles after the address is presented.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; all acks, mem_we, wait counter and starvation counter = 0.
  - Latched owner/we/adr/wd and cpu_rd/ld_rd = 0.
  - An in-flight access is abandoned. A write whose mem_we pulse has already issued is committed; nothing else is.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any req is high, arbitrate and latch owner, we, adr and wd from the winner.
  - Load cnt=WAIT_CYCLES and go to BUSY.
  - With no req, stay in IDLE; mem_adr/mem_wd hold their last values and mem_we=0.
- Arbitration (base): strict priority, CPU over loader.
- BUSY:
  - mem_adr/mem_wd are driven from the latches.
  - mem_we = latched we in the first BUSY cycle only (exactly one write pulse per access).
  - cnt decrements each cycle. When cnt==0 at the clock edge:
    - For a read, capture mem_rd into the owner's rd register.
    - Set the owner's ack and go to RESP.
  - BUSY lasts WAIT_CYCLES+1 cycles.
- RESP:
  - The owner's ack is 1 for exactly this cycle; the other ack stays 0.
  - Next state is always IDLE; no arbitration happens in RESP.
- Latency: req sampled in IDLE to ack high = WAIT_CYCLES+2 cycles. Back-to-back accesses by the same requester occur every WAIT_CYCLES+3 cycles.
- Requester contract:
  - Inputs are sampled only in IDLE.
  - A req dropped before ack while the requester is not the owner is simply never served.
  - Changes by the owner after the latch are ignored.
- Write accesses leave the rd registers unchanged.
- cpu_stall is high from cpu_req assertion through the cycle before cpu_ack, and low in the ack cycle.

Optional Feature:
- Macro MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit starvation counter increments on each CPU grant made while ld_req=1, saturating at STARVE_LIMIT.
  - When counter==STARVE_LIMIT and both reqs are high in IDLE, the loader wins and the counter clears.
  - The counter also clears on any loader grant, or when ld_req=0 at arbitration.
- Not defined: strict CPU priority; the loader can starve; the counter is absent.

Test Plan:
- Single CPU read, WAIT_CYCLES=1, cpu_adr=0x10, mem_rd returns 0xE3A01005 -> cpu_ack high exactly at cycle 3 after req; cpu_rd=0xE3A01005; ld_ack stays 0.
- Loader write, ld_adr=0x20, ld_wd=0xDEADBEEF -> mem_we high for exactly 1 cycle with mem_adr=0x20, mem_wd=0xDEADBEEF; ld_ack at cycle 3; ld_rd unchanged.
- Simultaneous cpu_req and ld_req in IDLE, guard off -> CPU served first (cpu_ack cycle 3); loader served next (ld_ack cycle 7); cpu_stall low at cycle 3.
- Guard on, STARVE_LIMIT=2, CPU and loader requesting continuously -> grant order CPU, CPU, LD, CPU, CPU, LD.
- Reset pulled low in the BUSY cycle of a CPU read -> all acks and mem_we go to 0 immediately; after release, state is IDLE and the CPU request restarts with full latency (ack 3 cycles after the first IDLE sample).
- WAIT_CYCLES=0, CPU reads 0x0 then 0x4 back-to-back -> acks 3 cycles apart; cpu_rd updates on each ack.
